// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit lookahead group per stage.
// Inter-group carry, partial sums and remaining operand bits are registered between stages.
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NSTG = WIDTH / GROUP;
    localparam int L    = NSTG - 1;

    if (GROUP < 1 || GROUP > WIDTH || (WIDTH % GROUP) != 0) begin : g_bad_cfg
        $error("cla_addsub_pipe: WIDTH must be a positive multiple of GROUP");
    end

    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Returns {carry_out, sum}; every carry is a flat sum of products
    function automatic logic [GROUP:0] grp_add(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             cin
    );
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             t;
        logic             pp;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & cin);
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    for (genvar k = 0; k < NSTG; k++) begin : stg
        localparam int LO = k * GROUP;
        localparam int BW = WIDTH - LO;

        logic             vld_i;
        logic [WIDTH-1:0] s_i;
        logic [BW-1:0]    b_i;
        logic             c_i;
        logic [TAG_W-1:0] tag_i;
        logic [GROUP:0]   r;
        logic [WIDTH-1:0] s_o;

        if (k == 0) begin : g_src
            assign vld_i = in_valid;
            assign s_i   = in_a;
            assign b_i   = in_sub ? ~in_b : in_b;
            assign c_i   = in_sub | in_cin;
            assign tag_i = in_tag;
        end else begin : g_src
            // s_q: low groups already summed, upper bits still operand A
            logic             vld_q;
            logic [WIDTH-1:0] s_q;
            logic [BW-1:0]    b_q;
            logic             c_q;
            logic [TAG_W-1:0] tag_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    s_q   <= '0;
                    b_q   <= '0;
                    c_q   <= 1'b0;
                    tag_q <= '0;
                end else if (adv) begin
                    vld_q <= stg[k-1].vld_i;
                    if (stg[k-1].vld_i) begin
                        s_q   <= stg[k-1].s_o;
                        b_q   <= stg[k-1].b_i[BW+GROUP-1:GROUP];
                        c_q   <= stg[k-1].r[GROUP];
                        tag_q <= stg[k-1].tag_i;
                    end
                end
            end

            assign vld_i = vld_q;
            assign s_i   = s_q;
            assign b_i   = b_q;
            assign c_i   = c_q;
            assign tag_i = tag_q;
        end

        assign r = grp_add(s_i[LO +: GROUP], b_i[GROUP-1:0], c_i);

        always_comb begin
            s_o             = s_i;
            s_o[LO +: GROUP] = r[GROUP-1:0];
        end
    end

    logic             last_vld;
    logic [WIDTH-1:0] last_sum;
    logic             last_cout;
    logic             last_ovf;
    logic [TAG_W-1:0] last_tag;

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit
    assign last_vld  = stg[L].vld_i;
    assign last_sum  = stg[L].s_o;
    assign last_cout = stg[L].r[GROUP];
    assign last_tag  = stg[L].tag_i;
    assign last_ovf  = stg[L].s_i[WIDTH-1] ^ stg[L].b_i[GROUP-1]
                     ^ last_sum[WIDTH-1] ^ last_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= last_vld;
            if (last_vld) begin
                out_sum  <= last_sum;
                out_cout <= last_cout;
                out_ovf  <= last_ovf;
                out_zero <= ~|last_sum;
                out_tag  <= last_tag;
            end
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed and randomised checks of cla_addsub_pipe in several configurations.
module tb_cla_addsub_pipe;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        d_valid = 1'b0;
    logic        d_irdy;
    logic [31:0] d_a = '0;
    logic [31:0] d_b = '0;
    logic        d_cin = 1'b0;
    logic        d_sub = 1'b0;
    logic [3:0]  d_tagi = '0;
    logic        d_ovalid;
    logic        d_ordy = 1'b1;
    logic [31:0] d_sum;
    logic        d_cout;
    logic        d_ovf;
    logic        d_zero;
    logic [3:0]  d_tago;

    cla_addsub_pipe #(.WIDTH(32), .GROUP(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_valid), .in_ready(d_irdy),
        .in_a(d_a), .in_b(d_b), .in_cin(d_cin), .in_sub(d_sub), .in_tag(d_tagi),
        .out_valid(d_ovalid), .out_ready(d_ordy),
        .out_sum(d_sum), .out_cout(d_cout), .out_ovf(d_ovf),
        .out_zero(d_zero), .out_tag(d_tago)
    );

    logic [2:0]  sw_valid = '0;
    logic [2:0]  sw_cin = '0;
    logic [2:0]  sw_sub = '0;
    logic [2:0]  sw_ordy = '1;
    logic [31:0] sw_a [3];
    logic [31:0] sw_b [3];
    logic [3:0]  sw_tagi [3];
    logic [2:0]  sw_irdy;
    logic [2:0]  sw_ovalid;
    logic [2:0]  sw_cout;
    logic [2:0]  sw_ovf;
    logic [2:0]  sw_zero;
    logic [31:0] sw_sum [3];
    logic [3:0]  sw_tago [3];
    logic [15:0] sum16;
    logic [7:0]  sum8;
    logic [11:0] sum12;

    assign sw_sum[0] = {16'h0, sum16};
    assign sw_sum[1] = {24'h0, sum8};
    assign sw_sum[2] = {20'h0, sum12};

    cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid[0]), .in_ready(sw_irdy[0]),
        .in_a(sw_a[0][15:0]), .in_b(sw_b[0][15:0]),
        .in_cin(sw_cin[0]), .in_sub(sw_sub[0]), .in_tag(sw_tagi[0]),
        .out_valid(sw_ovalid[0]), .out_ready(sw_ordy[0]),
        .out_sum(sum16), .out_cout(sw_cout[0]), .out_ovf(sw_ovf[0]),
        .out_zero(sw_zero[0]), .out_tag(sw_tago[0])
    );

    cla_addsub_pipe #(.WIDTH(8), .GROUP(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid[1]), .in_ready(sw_irdy[1]),
        .in_a(sw_a[1][7:0]), .in_b(sw_b[1][7:0]),
        .in_cin(sw_cin[1]), .in_sub(sw_sub[1]), .in_tag(sw_tagi[1]),
        .out_valid(sw_ovalid[1]), .out_ready(sw_ordy[1]),
        .out_sum(sum8), .out_cout(sw_cout[1]), .out_ovf(sw_ovf[1]),
        .out_zero(sw_zero[1]), .out_tag(sw_tago[1])
    );

    cla_addsub_pipe #(.WIDTH(12), .GROUP(1), .TAG_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid[2]), .in_ready(sw_irdy[2]),
        .in_a(sw_a[2][11:0]), .in_b(sw_b[2][11:0]),
        .in_cin(sw_cin[2]), .in_sub(sw_sub[2]), .in_tag(sw_tagi[2]),
        .out_valid(sw_ovalid[2]), .out_ready(sw_ordy[2]),
        .out_sum(sum12), .out_cout(sw_cout[2]), .out_ovf(sw_ovf[2]),
        .out_zero(sw_zero[2]), .out_tag(sw_tago[2])
    );

    // Reference result packed as {tag, zero, ovf, cout, sum}
    function automatic logic [38:0] ref_model(
        input int w, input logic [31:0] a, input logic [31:0] b,
        input logic cin, input logic sub, input logic [3:0] tag
    );
        logic [31:0] mask;
        logic [31:0] beff;
        logic [32:0] full;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        mask = (32'd1 << w) - 32'd1;
        beff = sub ? (~b & mask) : (b & mask);
        full = {1'b0, a & mask} + {1'b0, beff} + {32'd0, sub | cin};
        sum  = full[31:0] & mask;
        cout = full[w];
        ovf  = (a[w-1] == beff[w-1]) && (sum[w-1] != a[w-1]);
        return {tag, sum == 32'd0, ovf, cout, sum};
    endfunction

    task automatic run_op(
        input logic [31:0] a, input logic [31:0] b, input logic cin,
        input logic sub, input logic [3:0] tag,
        output logic [31:0] s, output logic co, output logic ov,
        output logic z, output logic [3:0] t, output int lat
    );
        @(negedge clk);
        d_valid = 1'b1;
        d_a = a;
        d_b = b;
        d_cin = cin;
        d_sub = sub;
        d_tagi = tag;
        d_ordy = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        d_valid = 1'b0;
        while (!d_ovalid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        s = d_sum;
        co = d_cout;
        ov = d_ovf;
        z = d_zero;
        t = d_tago;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (d_ovalid !== 1'b0 || sw_ovalid !== 3'b000) begin
            failures++;
            $display("FAIL reset_valid: got %b/%b want 0/000", d_ovalid, sw_ovalid);
        end
        checks++;
        if (d_sum !== 32'h0 || d_tago !== 4'h0) begin
            failures++;
            $display("FAIL reset_data: got sum=%h tag=%h want 0/0", d_sum, d_tago);
        end
        checks++;
        if ({d_cout, d_ovf, d_zero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000", {d_cout, d_ovf, d_zero});
        end
        checks++;
        if (d_irdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", d_irdy);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] s;
        logic co, ov, z;
        logic [3:0] t;
        int lat;
        run_op(32'h0000_00FF, 32'h1, 1'b0, 1'b0, 4'd3, s, co, ov, z, t, lat);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        checks++;
        if ({t, z, ov, co, s} !== {4'd3, 3'b000, 32'h0000_0100}) begin
            failures++;
            $display("FAIL basic_result: got tag=%h z=%b ov=%b co=%b sum=%h want 3/0/0/0/00000100",
                     t, z, ov, co, s);
        end
    endtask

    task automatic test_carry_chain();
        logic [31:0] s;
        logic co, ov, z;
        logic [3:0] t;
        int lat;
        run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'd5, s, co, ov, z, t, lat);
        checks++;
        if ({t, z, ov, co, s} !== {4'd5, 3'b101, 32'h0}) begin
            failures++;
            $display("FAIL carry_full: got tag=%h z=%b ov=%b co=%b sum=%h want 5/1/0/1/0",
                     t, z, ov, co, s);
        end
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd6, s, co, ov, z, t, lat);
        checks++;
        if ({t, z, ov, co, s} !== {4'd6, 3'b010, 32'h8000_0000}) begin
            failures++;
            $display("FAIL carry_ovf: got tag=%h z=%b ov=%b co=%b sum=%h want 6/0/1/0/80000000",
                     t, z, ov, co, s);
        end
    endtask

    task automatic test_subtract();
        logic [31:0] s;
        logic co, ov, z;
        logic [3:0] t;
        int lat;
        run_op(32'd5, 32'd7, 1'b1, 1'b1, 4'd7, s, co, ov, z, t, lat);
        checks++;
        if ({t, z, ov, co, s} !== {4'd7, 3'b000, 32'hFFFF_FFFE}) begin
            failures++;
            $display("FAIL sub_borrow: got tag=%h z=%b ov=%b co=%b sum=%h want 7/0/0/0/fffffffe",
                     t, z, ov, co, s);
        end
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'd8, s, co, ov, z, t, lat);
        checks++;
        if ({t, z, ov, co, s} !== {4'd8, 3'b011, 32'h7FFF_FFFF}) begin
            failures++;
            $display("FAIL sub_ovf: got tag=%h z=%b ov=%b co=%b sum=%h want 8/0/1/1/7fffffff",
                     t, z, ov, co, s);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic [31:0] psum = '0;
        logic [3:0] ptag = '0;
        while (got < 10 && cyc < 200) begin
            @(negedge clk);
            d_ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            d_valid = sent < 10;
            d_a = sent;
            d_b = sent;
            d_cin = 1'b0;
            d_sub = 1'b0;
            d_tagi = sent[3:0];
            #1;
            checks++;
            if (d_irdy !== (~d_ovalid | d_ordy)) begin
                failures++;
                $display("FAIL bp_in_ready: got %b want %b", d_irdy, ~d_ovalid | d_ordy);
            end
            if (stall) begin
                checks++;
                if (d_ovalid !== 1'b1 || d_sum !== psum || d_tago !== ptag) begin
                    failures++;
                    $display("FAIL bp_stable: got v=%b sum=%h tag=%h want 1/%h/%h",
                             d_ovalid, d_sum, d_tago, psum, ptag);
                end
            end
            stall = d_ovalid & ~d_ordy;
            psum = d_sum;
            ptag = d_tago;
            if (d_ovalid && d_ordy) begin
                checks++;
                if (d_sum !== 32'(2 * got) || d_tago !== got[3:0]) begin
                    failures++;
                    $display("FAIL bp_data: got sum=%h tag=%h want %h/%h",
                             d_sum, d_tago, 32'(2 * got), got[3:0]);
                end
                got++;
            end
            if (d_valid && d_irdy) sent++;
            cyc++;
        end
        checks++;
        if (got != 10) begin
            failures++;
            $display("FAIL bp_count: got %0d results want 10", got);
        end
        @(negedge clk);
        d_valid = 1'b0;
        d_ordy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (d_ovalid !== 1'b0) begin
                failures++;
                $display("FAIL bp_extra: got out_valid=%b want 0", d_ovalid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] s;
        logic co, ov, z;
        logic [3:0] t;
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_valid = 1'b1;
            d_ordy = 1'b1;
            d_a = 32'(10 + i);
            d_b = 32'h0;
            d_cin = 1'b0;
            d_sub = 1'b0;
            d_tagi = 4'(i + 1);
        end
        @(negedge clk);
        d_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (d_ovalid !== 1'b1 || d_sum !== 32'd10) begin
            failures++;
            $display("FAIL mid_first: got v=%b sum=%h want 1/0000000a", d_ovalid, d_sum);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d_ovalid, d_cout, d_ovf, d_zero} !== 4'b0000 || d_sum !== 32'h0 || d_tago !== 4'h0) begin
            failures++;
            $display("FAIL mid_async_clear: got v=%b sum=%h tag=%h flags=%b want all 0",
                     d_ovalid, d_sum, d_tago, {d_cout, d_ovf, d_zero});
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (d_ovalid !== 1'b0) begin
                failures++;
                $display("FAIL mid_ghost: got out_valid=%b want 0", d_ovalid);
            end
        end
        run_op(32'h12, 32'h34, 1'b0, 1'b0, 4'd9, s, co, ov, z, t, lat);
        checks++;
        if (lat != 4 || s !== 32'h46 || t !== 4'd9) begin
            failures++;
            $display("FAIL mid_after: got lat=%0d sum=%h tag=%h want 4/00000046/9", lat, s, t);
        end
    endtask

    task automatic test_sweep(input int ci, input int w, input int g, input int nbeats);
        logic [38:0] exp_q [$];
        logic [38:0] cur;
        logic [38:0] obs;
        logic [38:0] want;
        logic [31:0] mask;
        logic have = 1'b0;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int lat;
        mask = (32'd1 << w) - 32'd1;
        @(negedge clk);
        sw_valid[ci] = 1'b1;
        sw_ordy[ci] = 1'b1;
        sw_a[ci] = 32'd1;
        sw_b[ci] = 32'd2;
        sw_cin[ci] = 1'b0;
        sw_sub[ci] = 1'b0;
        sw_tagi[ci] = 4'd1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        sw_valid[ci] = 1'b0;
        while (!sw_ovalid[ci] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != w / g || sw_sum[ci] !== 32'd3) begin
            failures++;
            $display("FAIL sweep%0d_latency: got lat=%0d sum=%h want %0d/3", w, lat, sw_sum[ci], w / g);
        end
        while (got < nbeats && cyc < nbeats * 20) begin
            @(negedge clk);
            if (!have && sent < nbeats && $urandom_range(0, 3) != 0) begin
                sw_a[ci] = $urandom & mask;
                sw_b[ci] = $urandom & mask;
                sw_cin[ci] = 1'($urandom_range(0, 1));
                sw_sub[ci] = 1'($urandom_range(0, 1));
                sw_tagi[ci] = 4'($urandom_range(0, 15));
                cur = ref_model(w, sw_a[ci], sw_b[ci], sw_cin[ci], sw_sub[ci], sw_tagi[ci]);
                have = 1'b1;
            end
            sw_valid[ci] = have;
            sw_ordy[ci] = $urandom_range(0, 2) != 0;
            #1;
            if (sw_ovalid[ci] && sw_ordy[ci]) begin
                checks++;
                obs = {sw_tago[ci], sw_zero[ci], sw_ovf[ci], sw_cout[ci], sw_sum[ci]};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sweep%0d_spurious: got %h with nothing pending", w, obs);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want) begin
                        failures++;
                        $display("FAIL sweep%0d_result: got tag/z/ov/co/sum=%h want %h", w, obs, want);
                    end
                end
                got++;
            end
            if (have && sw_irdy[ci]) begin
                exp_q.push_back(cur);
                have = 1'b0;
                sent++;
            end
            cyc++;
        end
        checks++;
        if (got != nbeats) begin
            failures++;
            $display("FAIL sweep%0d_count: got %0d results want %0d", w, got, nbeats);
        end
        @(negedge clk);
        sw_valid[ci] = 1'b0;
        sw_ordy[ci] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            sw_a[i] = '0;
            sw_b[i] = '0;
            sw_tagi[i] = '0;
        end
        test_reset();
        test_basic();
        test_carry_chain();
        test_subtract();
        test_backpressure();
        test_reset_midflight();
        test_sweep(0, 16, 4, 1000);
        test_sweep(1, 8, 8, 1000);
        test_sweep(2, 12, 1, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the team's fixed 8-bit combinational CLA.
- Operand width is split into GROUP-bit lookahead groups. Each group resolves in its own pipeline stage, with the inter-group carry registered between stages.
- Sits between an operand producer and a result consumer, with valid/ready handshake and backpressure on both sides.
- Adds subtract mode, a sideband tag and status flags (carry, signed overflow, zero).

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP.
- GROUP, 8, bits per lookahead group; 1 <= GROUP <= WIDTH.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- NSTG (derived localparam, not overridable), WIDTH/GROUP, number of pipeline stages (= latency).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; in subtract mode, 1 = no borrow (A >= B unsigned).
- out_ovf  out  1  two's-complement overflow.
- out_zero  out  1  out_sum == 0.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0. out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, out_tag=0. Pipeline data registers cleared.
  - Reset asserted mid-operation discards all in-flight beats; none emerge after release.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv, combinational from out_valid/out_ready only; no combinational path from in_valid.
- Accept: in_valid & in_ready in cycle N. The result appears as out_valid=1 in cycle N+NSTG. Throughput is 1 beat/cycle while out_ready=1.
- When adv=0 every stage register holds, including valid bits. Bubbles are not compressed.
- Stage 0:
  - Captures a, b_eff = in_sub ? ~in_b : in_b, c0 = in_sub ? 1 : in_cin, tag, valid.
  - Computes group 0 sum and carry with full lookahead inside the group: per-bit p=a^b, g=a&b, c[i+1]=g[i]|p[i]&c[i] flattened.
- Stage k (1..NSTG-1): computes group k from the registered carry of stage k-1. Already-computed low sum bits and remaining high operand bits are forwarded.
- Final stage registers out_sum, out_cout = carry out of MSB, out_ovf = carry into MSB XOR carry out of MSB, out_zero = ~|out_sum, out_tag.
- out_* data holds stable while out_valid=1 & out_ready=0 (AXI-style). out_valid never deasserts without a handshake.
- NSTG=1 (GROUP=WIDTH): latency 1, same handshake rules.
- Simultaneous in-handshake and out-handshake in one cycle is legal and keeps full throughput.
- in_valid while in_ready=0: no capture. The producer must hold the beat; the block does not check this.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Test Plan:
- Defaults (WIDTH=32, GROUP=8, NSTG=4). A=0x0000_00FF, B=0x0000_0001, cin=0, sub=0, tag=3, out_ready=1:
  - out_valid rises exactly 4 cycles after accept.
  - sum=0x0000_0100, cout=0, ovf=0, zero=0, tag=3.
- Full carry chain across all groups. A=0xFFFF_FFFF, B=0, cin=1:
  - sum=0, cout=1, zero=1, ovf=0.
  - Then A=0x7FFF_FFFF, B=1, cin=0 -> sum=0x8000_0000, ovf=1, cout=0.
- Subtract. A=5, B=7, sub=1, cin=1 (must be ignored):
  - sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0.
  - Then A=0x8000_0000, B=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Backpressure. Stream 10 beats (A=i, B=i, tag=i) with out_ready toggling 1,0,0,1 repeating:
  - Results are 2*i in order with matching tags; none lost or duplicated.
  - in_ready mirrors ~out_valid|out_ready every cycle.
  - Output data is stable while stalled.
- Reset mid-flight. Accept 3 beats, assert rst_n=0 asynchronously between clock edges:
  - All outputs 0 immediately.
  - After release, out_valid stays 0 until new beats arrive 4 cycles later.
- Parameter sweep (WIDTH=16/GROUP=4, WIDTH=8/GROUP=8, WIDTH=12/GROUP=1):
  - 1000 random beats with random out_ready match a reference model for sum/cout/ovf/zero/tag.
  - Latency = WIDTH/GROUP in every configuration.
